// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants, FIFO entry type and helpers for the fetch stage
// Entry carries a misaligned flag only when IF_MISALIGN_TRAP_EN is defined.
package instr_fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
`ifdef IF_MISALIGN_TRAP_EN
    logic            misaligned;
`endif
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-3:0] word_index(input logic [XLEN-1:0] byte_addr);
    return byte_addr[XLEN-1:2];
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous count-based FIFO with flush, parameterised width/depth
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count/pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC generation and instruction fetch with in-order prefetch FIFO
// IF_MISALIGN_TRAP_EN adds if_misaligned and a trap entry for misaligned redirects.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic            if_misaligned
`endif
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  logic [XLEN-3:0] fetch_word;
  logic [XLEN-3:0] resp_word;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     inflight;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fetch_hold;
  logic            req_fire;
  logic            resp_keep;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Credits cover both words in flight and words already buffered, so a push never finds the FIFO full.
  assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !redirect_valid && !fetch_hold && (inflight < DEPTH_C);
  assign imem_req_addr  = {fetch_word, 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && (drop == '0) && !redirect_valid && !fetch_hold;

  assign if_valid = !fifo_empty;
  assign pop      = if_valid && if_ready;
  assign if_pc    = fifo_empty ? '0 : head.pc;
  assign if_instr = fifo_empty ? '0 : head.instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_word  <= word_index(RESET_PC);
      resp_word   <= word_index(RESET_PC);
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_word  <= word_index(redirect_pc);
      resp_word   <= word_index(redirect_pc);
      outstanding <= outstanding - CW'(imem_resp_valid);
      drop        <= outstanding - CW'(imem_resp_valid);
    end else begin
      if (req_fire)  fetch_word <= fetch_word + (XLEN-2)'(1);
      if (resp_keep) resp_word  <= resp_word + (XLEN-2)'(1);
      case ({req_fire, imem_resp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (imem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  localparam logic [1:0] TS_RUN  = 2'd0;
  localparam logic [1:0] TS_PUSH = 2'd1;
  localparam logic [1:0] TS_HOLD = 2'd2;

  logic [1:0]      trap_state;
  logic [XLEN-1:0] trap_pc;

  // The trap entry is pushed the cycle after the redirect, once the flush has emptied the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_state <= TS_RUN;
      trap_pc    <= '0;
    end else if (redirect_valid) begin
      trap_state <= (redirect_pc[1:0] != 2'b00) ? TS_PUSH : TS_RUN;
      trap_pc    <= redirect_pc;
    end else if (trap_state == TS_PUSH) begin
      trap_state <= TS_HOLD;
    end
  end

  assign fetch_hold    = (trap_state != TS_RUN);
  assign if_misaligned = if_valid && head.misaligned;

  always_comb begin
    push      = resp_keep;
    push_data = '{misaligned: 1'b0, pc: {resp_word, 2'b00}, instr: imem_resp_data};
    if (trap_state == TS_PUSH) begin
      push      = 1'b1;
      push_data = '{misaligned: 1'b1, pc: trap_pc, instr: NOP_INSTR};
    end
  end
`else
  logic redirect_lsb_unused;

  assign redirect_lsb_unused = |redirect_pc[1:0];
  assign fetch_hold          = 1'b0;
  assign push                = resp_keep;
  assign push_data           = '{pc: {resp_word, 2'b00}, instr: imem_resp_data};
`endif

  ifetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      assert (!(push && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and random scoreboard bench for instr_fetch
// Build with IF_MISALIGN_TRAP_EN to exercise the misaligned-redirect trap.
module tb_instr_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_misaligned;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .if_misaligned   (if_misaligned)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t        sb[$];
  mreq_t       mem_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          consumed = 0;
  logic [31:0] exp_req_pc = 32'h0;
  logic        trap_stall = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rnd_ready = 1'b0;
  bit          rnd_if = 1'b0;
  bit          rnd_redir = 1'b0;
  logic        hold_if_ready = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Memory and decode environment for the coming edge; memory answers strictly in order.
  task automatic drive_env();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (rst) begin
      mem_q.delete();
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if_ready       = rnd_if ? 1'($urandom_range(0, 1)) : hold_if_ready;
    if (rnd_redir && !rst && $urandom_range(0, 63) == 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'($urandom_range(0, 4095)) << 2;
    end
  endtask

  task automatic tick();
    exp_t e;
    #1;
    if (!rst) begin
      if (if_valid && if_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 32'(if_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, e.instr);
`ifdef IF_MISALIGN_TRAP_EN
          chk("if_misaligned", 32'(if_misaligned), 32'(e.mis));
`endif
          consumed++;
        end
      end else if (sb.size() == 0) begin
        chk("idle_valid", 32'(if_valid), 32'h0);
      end
      if (redirect_valid || trap_stall) chk("req_blocked", 32'(imem_req_valid), 32'h0);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req_pc);
        sb.push_back('{exp_req_pc, mem_word(exp_req_pc), 1'b0});
        mem_q.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_min, lat_max))});
        exp_req_pc += 32'd4;
      end
      if (redirect_valid) begin
        sb.delete();
`ifdef IF_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
          trap_stall = 1'b1;
          sb.push_back('{redirect_pc, 32'h0000_0013, 1'b1});
        end else begin
          trap_stall = 1'b0;
          exp_req_pc = redirect_pc;
        end
`else
        exp_req_pc = {redirect_pc[31:2], 2'b00};
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    drive_env();
  endtask

  task automatic wait_valid(input string tag, input int n);
    int k = 0;
    while (!if_valid && k < n) begin
      tick();
      k++;
    end
    chk(tag, 32'(if_valid), 32'h1);
  endtask

  initial begin
    int start;
    int k;
    redirect_pc = 32'h0;
    drive_env();

    // reset
    tick();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // streaming from reset, 1-cycle memory
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stream_valid", 32'(if_valid), 32'h1);
      chk("stream_pc", if_pc, 32'(i * 4));
      tick();
    end
    repeat (10) tick();

    // backpressure fills every credit, then drains without loss
    hold_if_ready = 1'b0;
    if_ready = 1'b0;
    repeat (12) tick();
    #1;
    chk("bp_req_valid", 32'(imem_req_valid), 32'h0);
    chk("bp_inflight", 32'(sb.size()), 32'(DEPTH));
    chk("bp_if_valid", 32'(if_valid), 32'h1);
    hold_if_ready = 1'b1;
    if_ready = 1'b1;
    repeat (20) tick();

    // redirect with two slow requests in flight
    hold_if_ready = 1'b0;
    if_ready = 1'b0;
    repeat (10) tick();
    lat_min = 4;
    lat_max = 4;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0080;
    tick();
    tick();
    tick();
    chk("inflight_at_redirect", 32'(mem_q.size()), 32'h2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    hold_if_ready = 1'b1;
    if_ready = 1'b1;
    tick();
    wait_valid("valid_after_0x100", 30);
    chk("redir_pc0", if_pc, 32'h0000_0100);
    tick();
    wait_valid("valid_after_0x104", 30);
    chk("redir_pc1", if_pc, 32'h0000_0104);

    // redirect coinciding with a response and a pop
    lat_min = 1;
    lat_max = 1;
    repeat (10) tick();
    k = 0;
    while (!(imem_resp_valid && if_valid) && k < 10) begin
      tick();
      k++;
    end
    chk("pre_redir_valid", 32'(if_valid), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    chk("post_redir_valid0", 32'(if_valid), 32'h0);
    tick();
    chk("post_redir_valid1", 32'(if_valid), 32'h0);
    wait_valid("valid_after_0x200", 20);
    chk("redir_pc_0x200", if_pc, 32'h0000_0200);

    // redirect target with low bits set
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    wait_valid("valid_after_0x102", 20);
`ifdef IF_MISALIGN_TRAP_EN
    chk("trap_pc", if_pc, 32'h0000_0102);
    chk("trap_instr", if_instr, 32'h0000_0013);
    chk("trap_flag", 32'(if_misaligned), 32'h1);
    repeat (10) tick();
    #1;
    chk("trap_no_req", 32'(imem_req_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    wait_valid("valid_after_0x300", 20);
    chk("resume_pc", if_pc, 32'h0000_0300);
`else
    chk("lowbit_pc", if_pc, 32'h0000_0100);
    chk("lowbit_instr", if_instr, mem_word(32'h0000_0100));
`endif
    repeat (5) tick();

    // random latency, ready and redirects
    lat_min = 1;
    lat_max = 4;
    rnd_ready = 1'b1;
    rnd_if = 1'b1;
    rnd_redir = 1'b1;
    start = consumed;
    k = 0;
    while ((consumed - start) < 1000 && k < 30000) begin
      tick();
      k++;
    end
    chk("random_consumed", 32'((consumed - start) >= 1000), 32'h1);
    rnd_ready = 1'b0;
    rnd_if = 1'b0;
    rnd_redir = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
